hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 8-bit five-stage core. It sits beside the IF/ID pipeline register and decides each cycle whether the PC and IF/ID advance, hold or flush. It also decides whether ID/EX receives a bubble or freezes. Stall sources are load-use hazards, taken branches resolved in EX, and multi-cycle data-memory waits; saturating counters track stall and flush cycles for performance debug.

---
 rtl/hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: decides PC / IF/ID / ID/EX advance, flush, bubble or freeze
// for load-use hazards, taken branches and data-memory waits, with saturating stall/flush counters.
module hazard_ctrl #(
  parameter int unsigned REG_W          = 3,
  parameter int unsigned BRANCH_PENALTY = 1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             id_ex_hold,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned     FL_W      = 2;
  localparam logic [FL_W-1:0] FL_RELOAD = FL_W'(BRANCH_PENALTY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  state_t          cur_state, nxt_state;
  state_t          saved_q, saved_d;
  state_t          eff_state;
  logic [FL_W-1:0] fl_q, fl_d;
  logic            load_use;

  assign load_use  = ex_mem_read &&
                     ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  // Leaving MEM_WAIT is zero-cycle: the first non-busy cycle acts as the saved state.
  assign eff_state = (cur_state == ST_MEM_WAIT) ? saved_q : cur_state;
  assign state     = cur_state;

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    id_ex_hold   = 1'b0;
    nxt_state    = cur_state;
    fl_d         = fl_q;
    saved_d      = saved_q;

    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (mem_busy) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_hold  = 1'b1;
      if (cur_state != ST_MEM_WAIT) begin
        saved_d   = cur_state;
        nxt_state = ST_MEM_WAIT;
      end
    end else begin
      nxt_state = eff_state;
      if (ex_branch_taken) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        if (BRANCH_PENALTY > 1) begin
          nxt_state = ST_FLUSH;
          fl_d      = FL_RELOAD;
        end else begin
          nxt_state = ST_RUN;
        end
      end else if (eff_state == ST_FLUSH) begin
        if_id_flush = 1'b1;
        fl_d        = fl_q - FL_W'(1);
        if (fl_q == FL_W'(1)) begin
          nxt_state = ST_RUN;
        end
      end else if (load_use) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= ST_RUN;
      saved_q   <= ST_RUN;
      fl_q      <= '0;
    end else begin
      cur_state <= nxt_state;
      saved_q   <= saved_d;
      fl_q      <= fl_d;
    end
  end

  // Saturating performance counters; reset cycles are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (if_id_flush && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (penalty 2 / 16-bit counters, penalty 3 / 4-bit counters)
// share stimulus and are compared every cycle against a pending-flush/frozen model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rt, ex_mem_read, ex_branch_taken, mem_busy;

  logic        pc_write_a, if_id_write_a, if_id_flush_a, id_ex_bubble_a, id_ex_hold_a;
  logic [1:0]  state_a;
  logic [15:0] stall_cnt_a, flush_cnt_a;
  logic        pc_write_b, if_id_write_b, if_id_flush_b, id_ex_bubble_b, id_ex_hold_b;
  logic [1:0]  state_b;
  logic [3:0]  stall_cnt_b, flush_cnt_b;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(3), .BRANCH_PENALTY(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .pc_write(pc_write_a), .if_id_write(if_id_write_a),
    .if_id_flush(if_id_flush_a), .id_ex_bubble(id_ex_bubble_a), .id_ex_hold(id_ex_hold_a),
    .state(state_a), .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
  );

  hazard_ctrl #(.REG_W(3), .BRANCH_PENALTY(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .pc_write(pc_write_b), .if_id_write(if_id_write_b),
    .if_id_flush(if_id_flush_b), .id_ex_bubble(id_ex_bubble_b), .id_ex_hold(id_ex_hold_b),
    .state(state_b), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
  );

  logic [4:0] ctrl_a, ctrl_b;
  assign ctrl_a = {pc_write_a, if_id_write_a, if_id_flush_a, id_ex_bubble_a, id_ex_hold_a};
  assign ctrl_b = {pc_write_b, if_id_write_b, if_id_flush_b, id_ex_bubble_b, id_ex_hold_b};

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  // Model: remaining flush cycles after the current one, and whether the pipe sits frozen.
  int pend[2];
  bit frozen[2];
  int stall[2];
  int flsh[2];
  int bp[2]   = '{2, 3};
  int cmax[2] = '{65535, 15};

  task automatic check(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic bit load_use_hit();
    return ex_mem_read && ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  endfunction

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold}
  function automatic logic [4:0] exp_out(input int i);
    if (rst)             return 5'b00110;
    if (mem_busy)        return 5'b00001;
    if (ex_branch_taken) return 5'b11110;
    if (pend[i] > 0)     return 5'b11100;
    if (load_use_hit())  return 5'b00010;
    return 5'b11000;
  endfunction

  function automatic int exp_state(input int i);
    if (frozen[i]) return 2;
    return (pend[i] > 0) ? 1 : 0;
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; frozen[i] = 1'b0; stall[i] = 0; flsh[i] = 0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [4:0] o;
      o = exp_out(i);
      if (rst) begin
        pend[i] = 0; frozen[i] = 1'b0; stall[i] = 0; flsh[i] = 0;
      end else begin
        if (!o[4] && stall[i] < cmax[i]) stall[i]++;
        if (o[2] && flsh[i] < cmax[i]) flsh[i]++;
        if (mem_busy) frozen[i] = 1'b1;
        else begin
          frozen[i] = 1'b0;
          if (ex_branch_taken) pend[i] = bp[i] - 1;
          else if (pend[i] > 0) pend[i]--;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ctrl_a",  int'(ctrl_a),      int'(exp_out(0)));
      check("state_a", int'(state_a),     exp_state(0));
      check("stall_a", int'(stall_cnt_a), stall[0]);
      check("flush_a", int'(flush_cnt_a), flsh[0]);
      check("ctrl_b",  int'(ctrl_b),      int'(exp_out(1)));
      check("state_b", int'(state_b),     exp_state(1));
      check("stall_b", int'(stall_cnt_b), stall[1]);
      check("flush_b", int'(flush_cnt_b), flsh[1]);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; ex_rd = '0;
    id_uses_rt = 1'b0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic rand_inputs();
    id_rs           = 3'($urandom_range(0, 3));
    id_rt           = 3'($urandom_range(0, 3));
    ex_rd           = 3'($urandom_range(0, 3));
    id_uses_rt      = ($urandom_range(0, 1) == 0);
    ex_mem_read     = ($urandom_range(0, 2) == 0);
    ex_branch_taken = ($urandom_range(0, 6) == 0);
    mem_busy        = ($urandom_range(0, 5) == 0);
  endtask

  initial begin
    rst = 1'b1;
    rand_inputs();
    nxt();
    chk_en = 1'b1;
    rand_inputs();
    @(negedge clk);
    check("rst_ctrl_a", int'(ctrl_a), 6);
    check("rst_ctrl_b", int'(ctrl_b), 6);
    nxt();
    rst = 1'b0;
    idle();
    @(negedge clk);
    check("post_rst_state_a", int'(state_a), 0);
    check("post_rst_stall_a", int'(stall_cnt_a), 0);
    check("post_rst_flush_a", int'(flush_cnt_a), 0);
    check("post_rst_pc_write_a", int'(pc_write_a), 1);

    // Load-use on rs, then rt match that is not used.
    nxt(); ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs = 3'd3;
    @(negedge clk); check("lu_ctrl_a", int'(ctrl_a), 5'b00010);
    nxt(); ex_mem_read = 1'b0;
    @(negedge clk); check("lu_after_ctrl_a", int'(ctrl_a), 5'b11000);
    check("lu_stall_a", int'(stall_cnt_a), 1);
    nxt(); ex_mem_read = 1'b1; id_rs = 3'd0; id_rt = 3'd3; id_uses_rt = 1'b0;
    @(negedge clk); check("lu_rt_unused_a", int'(ctrl_a), 5'b11000);

    // Taken branch, penalty 2 on dut_a.
    nxt(); idle(); ex_branch_taken = 1'b1;
    @(negedge clk); check("br0_ctrl_a", int'(ctrl_a), 5'b11110);
    check("br0_state_a", int'(state_a), 0);
    nxt(); idle();
    @(negedge clk); check("br1_ctrl_a", int'(ctrl_a), 5'b11100);
    check("br1_state_a", int'(state_a), 1);
    nxt();
    @(negedge clk); check("br2_ctrl_a", int'(ctrl_a), 5'b11000);
    check("br2_state_a", int'(state_a), 0);
    check("br_flush_a", int'(flush_cnt_a), 2);
    nxt(); nxt();

    // Branch then 3-cycle memory wait, penalty 3 on dut_b.
    ex_branch_taken = 1'b1;
    @(negedge clk); check("bm_br_ctrl_b", int'(ctrl_b), 5'b11110);
    nxt(); ex_branch_taken = 1'b0; mem_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); check("bm_hold_ctrl_b", int'(ctrl_b), 5'b00001);
      if (k > 0) check("bm_hold_state_b", int'(state_b), 2);
      nxt();
    end
    mem_busy = 1'b0;
    @(negedge clk); check("bm_f1_ctrl_b", int'(ctrl_b), 5'b11100);
    check("bm_f1_state_b", int'(state_b), 2);
    nxt();
    @(negedge clk); check("bm_f2_ctrl_b", int'(ctrl_b), 5'b11100);
    check("bm_f2_state_b", int'(state_b), 1);
    nxt();
    @(negedge clk); check("bm_end_ctrl_b", int'(ctrl_b), 5'b11000);
    check("bm_end_state_b", int'(state_b), 0);
    check("bm_flush_b", int'(flush_cnt_b), 6);
    check("bm_stall_b", int'(stall_cnt_b), 4);

    // Priority: mem_busy beats branch and load-use; branch re-presented afterwards.
    nxt(); mem_busy = 1'b1; ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 3'd5; id_rs = 3'd5;
    @(negedge clk); check("prio_ctrl_a", int'(ctrl_a), 5'b00001);
    check("prio_ctrl_b", int'(ctrl_b), 5'b00001);
    nxt(); mem_busy = 1'b0; ex_mem_read = 1'b0;
    @(negedge clk); check("prio_br_ctrl_a", int'(ctrl_a), 5'b11110);
    nxt(); idle();
    nxt(); nxt(); nxt();

    // Saturation of dut_b's 4-bit stall counter.
    mem_busy = 1'b1;
    repeat (20) nxt();
    idle();
    @(negedge clk); check("sat_stall_b", int'(stall_cnt_b), 15);
    check("sat_stall_a", int'(stall_cnt_a), 25);

    // Randomized traffic with occasional reset.
    for (int c = 0; c < 2000; c++) begin
      nxt();
      rand_inputs();
      rst = ($urandom_range(0, 63) == 0);
    end
    nxt(); rst = 1'b0; idle();
    nxt(); nxt();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
